// File: rtl/data_path_param.sv
// data_path_param
// Parametrised SMP datapath: DR/TR/AC and the ALU are DW bits wide, AR/PC/IR
// and the internal bus are AW (= 2*DW) bits wide, with NREG general registers.
// A single encoded multiplexer drives the bus. Memory is reached through a
// req/ack port with a timeout.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   bus_sel                 bus source: 0 zero, 1 MBR, 2 PC, 3 {DR,TR},
//                           4 DR, 5 TR, 6 R[rsel], 7 AC
//   AR/PC/DR/TR/IR/R/AC/F   load and increment strobes from the control unit
//   rsel                    general register index (read and write)
//   alu_op                  0 ADD 1 SUB 2 INC 3 CLR 4 AND 5 OR 6 XOR 7 NOT
//   mem_start, mem_wr       start an access (pulse), direction
//   mem_req/we/addr/wdata   request side of the memory port
//   mem_rdata, mem_ack      response side of the memory port
//   mem_busy, mem_err       access in progress, sticky timeout flag
//   PCout, IRout, ACoutput, Rout, z, n, c   architectural state views
//   dbg_state               memory FSM state (0 IDLE, 1 REQ, 2 DONE)
//
// Memory handshake: mem_req is high only in REQ. The memory answers with a
// single-cycle mem_ack while mem_req is high; mem_rdata is sampled with it.
// mem_addr and mem_we are stable for the whole time mem_req is high.
module data_path_param #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int NREG = 4,
  parameter int TMO  = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                bus_sel,
  input  logic                      ARload,
  input  logic                      ARinc,
  input  logic                      PCload,
  input  logic                      PCinc,
  input  logic                      DRload,
  input  logic                      TRload,
  input  logic                      IRload,
  input  logic                      Rload,
  input  logic                      ACload,
  input  logic                      Fload,
  input  logic [$clog2(NREG)-1:0]   rsel,
  input  logic [2:0]                alu_op,
  input  logic                      mem_start,
  input  logic                      mem_wr,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata,
  input  logic                      mem_ack,
  output logic                      mem_busy,
  output logic                      mem_err,
  output logic [AW-1:0]             PCout,
  output logic [AW-1:0]             IRout,
  output logic [DW-1:0]             ACoutput,
  output logic [DW-1:0]             Rout,
  output logic                      z,
  output logic                      n,
  output logic                      c,
  output logic [1:0]                dbg_state
);

  localparam int RSW = $clog2(NREG);
  localparam int CW  = 8;

  if (AW != 2 * DW) begin : g_bad_aw
    $error("data_path_param: AW must equal 2*DW");
  end
  if ((NREG < 2) || ((NREG & (NREG - 1)) != 0)) begin : g_bad_nreg
    $error("data_path_param: NREG must be a power of two >= 2");
  end
  if ((TMO < 1) || (TMO > 255)) begin : g_bad_tmo
    $error("data_path_param: TMO must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} mem_state_t;

  logic [AW-1:0] r_ar, r_pc, r_ir;
  logic [DW-1:0] r_dr, r_tr, r_ac, r_mbr, r_wdata;
  logic [DW-1:0] r_regs [NREG];
  logic          r_z, r_n, r_c, r_err, r_we;
  logic [CW-1:0] r_cnt;
  mem_state_t    r_state;

  logic [AW-1:0] w_bus;
  logic [DW-1:0] w_b, w_alu;
  logic [DW:0]   w_sum;
  logic          w_carry;
  mem_state_t    w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_capture, w_mbr_ld, w_err_set, w_busy;

  // Bus multiplexer
  always_comb begin
    w_bus = '0;
    case (bus_sel)
      3'd1:    w_bus = AW'(r_mbr);
      3'd2:    w_bus = r_pc;
      3'd3:    w_bus = {r_dr, r_tr};
      3'd4:    w_bus = AW'(r_dr);
      3'd5:    w_bus = AW'(r_tr);
      3'd6:    w_bus = AW'(r_regs[rsel]);
      3'd7:    w_bus = AW'(r_ac);
      default: w_bus = '0;
    endcase
  end

  assign w_b = w_bus[DW-1:0];

  // ALU: A = AC, B = low half of the bus. For SUB the carry flag is a borrow.
  always_comb begin
    w_alu   = '0;
    w_carry = 1'b0;
    w_sum   = '0;
    case (alu_op)
      3'd0: begin
        w_sum   = {1'b0, r_ac} + {1'b0, w_b};
        w_alu   = w_sum[DW-1:0];
        w_carry = w_sum[DW];
      end
      3'd1: begin
        w_alu   = r_ac - w_b;
        w_carry = (r_ac < w_b);
      end
      3'd2: begin
        w_sum   = {1'b0, r_ac} + (DW+1)'(1);
        w_alu   = w_sum[DW-1:0];
        w_carry = w_sum[DW];
      end
      3'd4:    w_alu = r_ac & w_b;
      3'd5:    w_alu = r_ac | w_b;
      3'd6:    w_alu = r_ac ^ w_b;
      3'd7:    w_alu = ~r_ac;
      default: w_alu = '0;
    endcase
  end

  // Memory FSM next state
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    w_mbr_ld   = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_start) begin
          w_state_nx = S_REQ;
          w_cnt_nx   = '0;
          w_capture  = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_state_nx = S_DONE;
          w_mbr_ld   = ~r_we;
        end else if (r_cnt == CW'(TMO - 1)) begin
          w_state_nx = S_IDLE;
          w_err_set  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_busy = (r_state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ar    <= '0;
      r_pc    <= '0;
      r_ir    <= '0;
      r_dr    <= '0;
      r_tr    <= '0;
      r_ac    <= '0;
      r_mbr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_capture) begin
        r_we    <= mem_wr;
        r_wdata <= w_b;
      end
      if (w_mbr_ld)  r_mbr <= mem_rdata;
      if (w_err_set) r_err <= 1'b1;
      // AR is frozen during an access so the address cannot move under a request
      if (!w_busy) begin
        if (ARload)     r_ar <= w_bus;
        else if (ARinc) r_ar <= r_ar + AW'(1);
      end
      if (PCload)     r_pc <= w_bus;
      else if (PCinc) r_pc <= r_pc + AW'(1);
      if (DRload) r_dr <= w_b;
      if (TRload) r_tr <= r_dr;
      if (IRload) r_ir <= AW'(r_dr);
      if (Rload)  r_regs[rsel] <= w_b;
      if (ACload) r_ac <= w_alu;
      if (Fload) begin
        r_z <= (w_alu == '0);
        r_n <= w_alu[DW-1];
        r_c <= w_carry;
      end
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_we & mem_req;
  assign mem_addr  = r_ar;
  assign mem_wdata = r_wdata;
  assign mem_busy  = w_busy;
  assign mem_err   = r_err;
  assign PCout     = r_pc;
  assign IRout     = r_ir;
  assign ACoutput  = r_ac;
  assign Rout      = r_regs[rsel];
  assign z         = r_z;
  assign n         = r_n;
  assign c         = r_c;
  assign dbg_state = r_state;

  logic [RSW-1:0] w_unused_rsw;
  assign w_unused_rsw = rsel;

endmodule

// File: tb/tb_data_path_param.sv
// Directed bench for data_path_param with hand-computed expected values.
module tb_data_path_param;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int NREG = 4;
  localparam int TMO  = 15;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_INC = 3'd2, OP_CLR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_NOT = 3'd7;
  localparam logic [2:0] B_ZERO = 3'd0, B_MBR = 3'd1, B_PC = 3'd2, B_DRTR = 3'd3;
  localparam logic [2:0] B_DR   = 3'd4, B_TR  = 3'd5, B_R  = 3'd6, B_AC   = 3'd7;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [2:0]    bus_sel;
  logic          ARload, ARinc, PCload, PCinc, DRload, TRload, IRload, Rload, ACload, Fload;
  logic [1:0]    rsel;
  logic [2:0]    alu_op;
  logic          mem_start, mem_wr, mem_req, mem_we, mem_ack, mem_busy, mem_err;
  logic [AW-1:0] mem_addr, PCout, IRout;
  logic [DW-1:0] mem_wdata, mem_rdata, ACoutput, Rout;
  logic          z, n, c;
  logic [1:0]    dbg_state;

  data_path_param #(.DW(DW), .AW(AW), .NREG(NREG), .TMO(TMO)) dut (
    .clock(clock), .reset(reset), .bus_sel(bus_sel),
    .ARload(ARload), .ARinc(ARinc), .PCload(PCload), .PCinc(PCinc),
    .DRload(DRload), .TRload(TRload), .IRload(IRload), .Rload(Rload),
    .ACload(ACload), .Fload(Fload), .rsel(rsel), .alu_op(alu_op),
    .mem_start(mem_start), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_busy(mem_busy), .mem_err(mem_err),
    .PCout(PCout), .IRout(IRout), .ACoutput(ACoutput), .Rout(Rout),
    .z(z), .n(n), .c(c), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus_sel = B_ZERO; ARload = 0; ARinc = 0; PCload = 0; PCinc = 0;
    DRload = 0; TRload = 0; IRload = 0; Rload = 0; ACload = 0; Fload = 0;
    rsel = 2'd0; alu_op = OP_ADD; mem_start = 0; mem_wr = 0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_alu(input logic [2:0] sel, input logic [2:0] op,
                        input logic acld, input logic fld);
    bus_sel = sel; alu_op = op; ACload = acld; Fload = fld;
    tick();
    ACload = 0; Fload = 0;
  endtask

  // Starts an access with the current bus contents and plays the memory:
  // ack on the ack_at-th request cycle (0 = never). Bounded by 300 cycles.
  task automatic mem_access(input logic wr, input int ack_at, input logic [DW-1:0] rd,
                            input logic poke_ar, output int req_cycles,
                            output logic addr_ok, output logic we_seen,
                            output logic [DW-1:0] wdata_seen);
    logic [AW-1:0] addr0;
    addr0 = mem_addr;
    mem_wr = wr; mem_start = 1;
    tick();
    mem_start = 0; mem_wr = 0;
    req_cycles = 0; addr_ok = 1; we_seen = 0; wdata_seen = '0;
    for (int i = 0; i < 300; i++) begin
      if (!mem_req) break;
      req_cycles++;
      if (mem_addr !== addr0) addr_ok = 0;
      we_seen = mem_we;
      wdata_seen = mem_wdata;
      ARinc = poke_ar;
      if (req_cycles == ack_at) begin
        mem_ack = 1; mem_rdata = rd;
      end
      tick();
      ARinc = 0; mem_ack = 0; mem_rdata = '0;
    end
  endtask

  int            rc;
  logic          aok, wes;
  logic [DW-1:0] wds;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (3) tick();

    check("rst_pc", PCout, 16'h0000);
    check("rst_ir", IRout, 16'h0000);
    check("rst_ac", ACoutput, 8'h00);
    check("rst_rout", Rout, 8'h00);
    check("rst_flags", {z, n, c}, 3'b000);
    check("rst_req", mem_req, 1'b0);
    check("rst_busy", mem_busy, 1'b0);
    check("rst_err", mem_err, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_state", dbg_state, 2'd0);

    // AC = ~0 = FF with flags, then DR = FF, AC = 1, ADD DR
    do_alu(B_ZERO, OP_NOT, 1, 1);
    check("not_ac", ACoutput, 8'hFF);
    check("not_flags", {z, n, c}, 3'b010);
    bus_sel = B_AC; DRload = 1; tick(); DRload = 0;
    do_alu(B_ZERO, OP_CLR, 1, 0);
    do_alu(B_ZERO, OP_INC, 1, 0);
    check("inc_ac", ACoutput, 8'h01);
    do_alu(B_DR, OP_ADD, 1, 1);
    check("add_ac", ACoutput, 8'h00);
    check("add_flags", {z, n, c}, 3'b101);

    // Build AR = 0x1234 from two reads at address 0
    bus_sel = B_DR;
    mem_access(0, 1, 8'h34, 0, rc, aok, wes, wds);
    check("rd1_cycles", rc, 1);
    bus_sel = B_MBR; DRload = 1; tick(); DRload = 0;
    TRload = 1; tick(); TRload = 0;
    mem_access(0, 1, 8'h12, 0, rc, aok, wes, wds);
    bus_sel = B_MBR; DRload = 1; tick(); DRload = 0;
    bus_sel = B_DRTR; ARload = 1; tick(); ARload = 0;
    check("ar_load", mem_addr, 16'h1234);

    // Read with ack on the third request cycle; ARinc poked during REQ
    bus_sel = B_DR;
    mem_access(0, 3, 8'hA5, 1, rc, aok, wes, wds);
    check("rd_cycles", rc, 3);
    check("rd_addr_stable", aok, 1'b1);
    check("rd_we", wes, 1'b0);
    check("rd_done_busy", {mem_busy, mem_req}, 2'b10);
    bus_sel = B_MBR; DRload = 1; tick(); DRload = 0;
    IRload = 1; tick(); IRload = 0;
    check("ir_from_dr", IRout, 16'h00A5);
    check("ar_after_rd", mem_addr, 16'h1234);

    // Stray ack in IDLE must not touch MBR
    mem_ack = 1; mem_rdata = 8'hEE; tick(); mem_ack = 0; mem_rdata = '0;
    check("idle_ack_state", dbg_state, 2'd0);
    bus_sel = B_MBR; rsel = 2'd0; Rload = 1; tick(); Rload = 0;
    check("mbr_kept", Rout, 8'hA5);

    // Write of 0x3C with no ack -> timeout
    bus_sel = B_DR;
    mem_access(0, 2, 8'h3C, 0, rc, aok, wes, wds);
    check("rd3c_cycles", rc, 2);
    tick();
    bus_sel = B_MBR;
    mem_access(1, 0, 8'h00, 0, rc, aok, wes, wds);
    check("tmo_cycles", rc, TMO);
    check("tmo_we", wes, 1'b1);
    check("tmo_wdata", wds, 8'h3C);
    check("tmo_err", mem_err, 1'b1);
    check("tmo_idle", {mem_busy, mem_req, dbg_state}, 4'b0000);
    rsel = 2'd1; Rload = 1; tick(); Rload = 0;
    check("tmo_mbr_kept", Rout, 8'h3C);

    // Next access after timeout completes normally; a write leaves MBR alone
    bus_sel = B_AC;
    mem_access(1, 4, 8'h99, 0, rc, aok, wes, wds);
    check("wr2_cycles", rc, 4);
    check("wr2_wdata", wds, 8'h00);
    check("wr2_err_sticky", mem_err, 1'b1);
    check("wr2_done_busy", mem_busy, 1'b1);
    tick();
    bus_sel = B_MBR; rsel = 2'd1; Rload = 1; tick(); Rload = 0;
    check("wr2_mbr_kept", Rout, 8'h3C);

    // PC: load wins over inc, then wrap
    do_alu(B_ZERO, OP_CLR, 1, 0);
    do_alu(B_ZERO, OP_NOT, 1, 0);
    bus_sel = B_AC; DRload = 1; tick(); DRload = 0;
    TRload = 1; tick(); TRload = 0;
    bus_sel = B_DRTR; PCload = 1; PCinc = 1; tick(); PCload = 0;
    check("pc_load_wins", PCout, 16'hFFFF);
    tick();
    check("pc_wrap", PCout, 16'h0000);
    tick(); PCinc = 0;
    check("pc_inc", PCout, 16'h0001);

    // Read-during-write on R[2]
    bus_sel = B_ZERO;
    mem_access(0, 2, 8'h11, 0, rc, aok, wes, wds);
    bus_sel = B_MBR; rsel = 2'd2; Rload = 1; tick(); Rload = 0;
    do_alu(B_ZERO, OP_CLR, 1, 0);
    do_alu(B_MBR, OP_ADD, 1, 0);
    check("ac_11", ACoutput, 8'h11);
    rsel = 2'd2; Rload = 1;
    do_alu(B_R, OP_SUB, 0, 1);
    Rload = 0;
    check("rdw_flags", {z, n, c}, 3'b100);
    check("rdw_r2", Rout, 8'h11);
    check("rdw_ac_kept", ACoutput, 8'h11);

    // AC = 0x7F into R[3]
    bus_sel = B_ZERO;
    mem_access(0, 1, 8'h7F, 0, rc, aok, wes, wds);
    do_alu(B_ZERO, OP_CLR, 1, 0);
    do_alu(B_MBR, OP_ADD, 1, 1);
    check("ac_7f_flags", {z, n, c}, 3'b000);
    bus_sel = B_AC; rsel = 2'd3; Rload = 1; tick(); Rload = 0;
    check("r3_7f", Rout, 8'h7F);

    // More ALU ops (rsel=2 -> R[2] = 0x11, MBR = 0x7F)
    rsel = 2'd2;
    do_alu(B_R, OP_SUB, 1, 1);
    check("sub_ac", ACoutput, 8'h6E);
    check("sub_flags", {z, n, c}, 3'b000);
    do_alu(B_MBR, OP_SUB, 0, 1);
    check("borrow_flags", {z, n, c}, 3'b011);
    check("borrow_ac_kept", ACoutput, 8'h6E);
    do_alu(B_MBR, OP_XOR, 1, 1);
    check("xor_ac", ACoutput, 8'h11);
    do_alu(B_MBR, OP_OR, 1, 0);
    check("or_ac", ACoutput, 8'h7F);
    do_alu(B_R, OP_AND, 1, 0);
    check("and_ac", ACoutput, 8'h11);
    do_alu(B_ZERO, OP_CLR, 1, 0);
    do_alu(B_ZERO, OP_NOT, 1, 0);
    do_alu(B_ZERO, OP_INC, 1, 1);
    check("inc_wrap_ac", ACoutput, 8'h00);
    check("inc_wrap_flags", {z, n, c}, 3'b101);

    // Reset in the middle of a request drops mem_req at once
    bus_sel = B_ZERO; mem_start = 1; tick(); mem_start = 0;
    tick();
    check("pre_rst_req", mem_req, 1'b1);
    #2 reset = 1;
    #1;
    check("async_rst_req", mem_req, 1'b0);
    check("async_rst_err", mem_err, 1'b0);
    check("async_rst_pc", PCout, 16'h0000);
    @(negedge clock) reset = 0;
    tick();
    check("post_rst_busy", mem_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_path_param.md
Name: data_path_param

Overview:
- Parametrised successor to the 8-bit SMP datapath. Generalises data width, address width and general-register count.
- Replaces the tri-state bus with a single encoded bus multiplexer. Adds Z/N/C flags.
- Replaces the synchronous SRAM with an external req/ack memory port that has a timeout.
- Sits between the SMP control unit, which drives the per-cycle control strobes, and the memory subsystem.

Parameters:
- DW, 8: data width of DR, TR, R[n], AC and the ALU.
- AW, 16: address width of AR, PC, IR and the bus. Must equal 2*DW; elaboration error otherwise.
- NREG, 4: number of general registers R[0..NREG-1]. Power of two, ≥2. RSW = log2(NREG).
- TMO, 15: maximum cycles mem_req waits for mem_ack before abort. Range 1..255.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- bus_sel  in  3  bus source: 0 zero, 1 MBR, 2 PC, 3 {DR,TR}, 4 DR, 5 TR, 6 R[rsel], 7 AC
- ARload, ARinc, PCload, PCinc  in  1 each  AR/PC load from bus, increment
- DRload, TRload, IRload, Rload, ACload, Fload  in  1 each  register load strobes
- rsel  in  RSW  general-register index, used for both read and write
- alu_op  in  3  0 ADD, 1 SUB, 2 INC, 3 CLR, 4 AND, 5 OR, 6 XOR, 7 NOT
- mem_start  in  1  start a memory access (pulse)
- mem_wr  in  1  1 = write, 0 = read; sampled with mem_start
- mem_req  out  1  request to memory
- mem_we  out  1  write enable, valid while mem_req
- mem_addr  out  AW  AR contents
- mem_wdata  out  DW  write data captured at start
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge
- mem_busy  out  1  access in progress
- mem_err  out  1  sticky timeout flag
- PCout  out  AW  PC contents
- IRout  out  AW  IR contents
- ACoutput  out  DW  AC contents
- Rout  out  DW  R[rsel] contents
- z, n, c  out  1 each  zero, negative and carry flags

Behaviour:
- Reset (asynchronous, active-high): AR, PC, IR, DR, TR, every R[n], AC, MBR, z, n, c, mem_err all 0. FSM goes to IDLE. mem_req = mem_we = mem_busy = 0. Timeout counter = 0.
- Bus:
  - Purely combinational, AW wide.
  - DW-wide sources are zero-extended.
  - Sel 3 places DR in the upper DW bits and TR in the lower DW bits.
  - Exactly one source at a time, so no contention is possible.
- Register loads are synchronous:
  - AR, PC load bus[AW-1:0].
  - DR, R[rsel] load bus[DW-1:0].
  - TR loads DR.
  - IR loads {zeros, DR} (zero-extended).
  - AC loads the ALU result.
- AR and PC:
  - Load and increment asserted together: load wins.
  - Increment wraps from all-ones to 0.
- Read-during-write on R[rsel] with bus_sel 6: the bus carries the old value; the new value is visible the next cycle.
- ALU:
  - Operands: A = AC, B = bus[DW-1:0]. Arithmetic is modulo 2^DW.
  - c is the carry-out for ADD/INC. For SUB, c is the borrow (A < B unsigned).
  - c = 0 for logical ops and for CLR.
  - NOT yields ~A.
- Flags:
  - On Fload: z = (result == 0), n = result[DW-1], c as defined above.
  - Fload is independent of ACload.
- Memory FSM, IDLE / REQ / DONE:
  - IDLE with mem_start: capture mem_we = mem_wr and mem_wdata = bus[DW-1:0]. Enter REQ with counter = 0. mem_req and mem_busy go high the next cycle.
  - REQ, mem_ack = 1: on a read, MBR <= mem_rdata. Go to DONE and drop mem_req.
  - REQ, no ack, counter == TMO-1: set mem_err, drop mem_req, go to IDLE. MBR is unchanged.
  - REQ otherwise: counter +1.
  - DONE lasts one cycle with mem_busy = 1, then returns to IDLE. MBR is valid on the bus (sel 1) from DONE onward.
- Busy-time rules:
  - mem_start while busy: ignored.
  - ARload/ARinc while busy: ignored, so mem_addr is stable for the whole request.
  - mem_ack in IDLE or DONE: ignored.
- mem_err is cleared only by reset. A new access may start after a timeout.
- Reset during REQ: mem_req drops immediately (asynchronous); the access is abandoned.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0, mem_req = 0, PCout = 0x0000.
- bus_sel = 4 with DR = 0xFF, AC = 0x01, alu_op ADD, ACload + Fload -> ACoutput = 0x00, z = 1, c = 1, n = 0.
- AR = 0x1234, mem_start read; ack after 3 cycles with rdata = 0xA5 -> mem_req high exactly 3 cycles, mem_addr = 0x1234 throughout. bus_sel = 1 then DRload -> DR = 0xA5.
- mem_start write with bus = 0x3C, no ack, TMO = 15 -> mem_req high 15 cycles, then mem_err = 1, FSM returns to IDLE. A second access with an ack completes normally.
- PCload and PCinc together, bus = 0xFFFF -> PC = 0xFFFF. Next cycle PCinc only -> PC = 0x0000.
- Rload rsel = 2 with bus_sel = 6 and R[2] = 0x11, AC = 0x11, SUB with Fload -> z = 1 (old value used), R[2] = 0x11. Then Rload rsel = 3 from AC = 0x7F -> Rout (rsel = 3) = 0x7F next cycle.
